control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter OPCODE_W, default 4, width of the opcode field taken from the instruction register.
REQ-002 Parameter ALU_OP_W, default 3, width of the ALU operation select.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 opcode  input  OPCODE_W  registered instruction opcode.
REQ-006 alu_zero  input  1  combinational ALU zero result for the current cycle.
REQ-007 mem_ready  input  1  data-memory completion strobe; ignored when MEM_WAIT_EN is undefined.
REQ-008 pc_we, pc_sel  output  1 each  PC load enable; next-PC select (0 = PC+1, 1 = branch/jump target).
REQ-009 ir_we, reg_ab_we, acc_we, mar_we, mdr_we, flags_we  output  1 each  datapath register load enables.
REQ-010 rf_we, rf_wsel  output  1 each  register-file write enable; write-data select (0 = ACC, 1 = MDR).
REQ-011 alu_op  output  ALU_OP_W  ADD=000, SUB=001, AND=010, OR=011, PASS_B=100.
REQ-012 alu_src_b, imm_sel  output  1, 2  ALU B select (0 = reg B, 1 = immediate); extender select (0 = imm4, 1 = imm8, 2 = imm12).
REQ-013 mem_re, mem_we  output  1 each  data-memory read and write strobes.
REQ-014 halted, state  output  1, 3  halt indicator; current state encoding, for debug.

Function
REQ-015 States and encodings: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; encoding 7 unreachable, decoded as HALT.
REQ-016 Outputs are decoded combinationally from state and opcode; any strobe not listed for a state is 0.
REQ-017 BOOT: all outputs 0; next state FETCH.
REQ-018 FETCH: ir_we=1, pc_we=1, pc_sel=0; next state DECODE.
REQ-019 DECODE: reg_ab_we=1; JMP (0x9) also asserts pc_we=1, pc_sel=1, imm_sel=2 and goes to FETCH; NOP (0x0) goes to FETCH; HLT (0xF) goes to HALT; opcodes 0xA-0xE go to HALT; all others go to EXEC.
REQ-020 EXEC, ADD/SUB/AND/OR (0x1-0x4): alu_op per opcode, alu_src_b=0, acc_we=1, flags_we=1; next state WB.
REQ-021 EXEC, ADDI (0x5): alu_op=ADD, alu_src_b=1, imm_sel=0, acc_we=1, flags_we=1; next state WB.
REQ-022 EXEC, LD/ST (0x6/0x7): alu_op=ADD, alu_src_b=1, imm_sel=1, mar_we=1; next state MEM.
REQ-023 EXEC, BEQ (0x8): alu_op=SUB, alu_src_b=0, flags_we=1, imm_sel=2; pc_we=pc_sel=alu_zero in the same cycle; next state FETCH.
REQ-024 MEM, LD: mem_re=1, mdr_we=1; next state WB. MEM, ST: mem_we=1; next state FETCH.
REQ-025 WB: rf_we=1; rf_wsel=1 for LD, 0 otherwise; next state FETCH.
REQ-026 HALT: halted=1, all other strobes 0; left only by reset.
REQ-027 Latency in cycles, FETCH to next FETCH: JMP/NOP 2, BEQ 3, ALU/ADDI/ST 4, LD 5.

Reset
REQ-028 rst_n low forces state to BOOT immediately, regardless of clock; all outputs read 0 while rst_n is low.
REQ-029 Reset asserted mid-instruction abandons it; no write strobe is asserted after the asynchronous assertion.
REQ-030 After rst_n deasserts, the first rising edge moves BOOT to FETCH.

Configuration
REQ-031 Macro MEM_WAIT_EN defined: the MEM state holds, with its strobes asserted, until mem_ready=1; it advances on the edge where mem_ready=1. mdr_we is asserted only while mem_ready=1.
REQ-032 MEM_WAIT_EN undefined: MEM lasts exactly one cycle and mem_ready is unused.

Verification
REQ-033 Release reset -> state 0 for one cycle, then 1; all outputs 0 during and immediately after reset.
REQ-034 ADD (0x1) -> states 1,2,3,5,1; acc_we and flags_we in state 3; rf_we=1, rf_wsel=0 in state 5.
REQ-035 LD (0x6) with MEM_WAIT_EN and mem_ready low 3 cycles -> state 4 held 4 cycles; mdr_we only in the last; then state 5 with rf_wsel=1.
REQ-036 BEQ (0x8) with alu_zero=1 -> pc_we=1, pc_sel=1 in state 3; with alu_zero=0 -> pc_we=0; both return to state 1.
REQ-037 Opcode 0xC, then 0xF -> each reaches state 6 with halted=1 and stays for 20 cycles; rst_n pulse -> state 0.
REQ-038 rst_n asserted during ST in state 4 -> mem_we drops to 0 asynchronously and state reads 0.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: BOOT/FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with decoded strobes.
// Optional MEM_WAIT_EN: hold MEM until mem_ready; otherwise MEM is a single cycle.
module control_unit #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                pc_we,
  output logic                pc_sel,
  output logic                ir_we,
  output logic                reg_ab_we,
  output logic                acc_we,
  output logic                mar_we,
  output logic                mdr_we,
  output logic                flags_we,
  output logic                rf_we,
  output logic                rf_wsel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_b,
  output logic [1:0]          imm_sel,
  output logic                mem_re,
  output logic                mem_we,
  output logic                halted,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(4'h0);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(4'h7);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(4'h8);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(4'h9);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3'b000);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3'b001);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(3'b010);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3'b011);

  state_t r_state;
  state_t w_next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BOOT;
    else        r_state <= w_next_state;
  end

  assign state = r_state;

`ifndef MEM_WAIT_EN
  logic w_unused;
  assign w_unused = mem_ready;
`endif

  always_comb begin
    w_next_state = r_state;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    ir_we        = 1'b0;
    reg_ab_we    = 1'b0;
    acc_we       = 1'b0;
    mar_we       = 1'b0;
    mdr_we       = 1'b0;
    flags_we     = 1'b0;
    rf_we        = 1'b0;
    rf_wsel      = 1'b0;
    alu_op       = ALU_ADD;
    alu_src_b    = 1'b0;
    imm_sel      = 2'd0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    halted       = 1'b0;

    case (r_state)
      S_BOOT: w_next_state = S_FETCH;

      S_FETCH: begin
        ir_we        = 1'b1;
        pc_we        = 1'b1;
        w_next_state = S_DECODE;
      end

      S_DECODE: begin
        reg_ab_we = 1'b1;
        case (opcode)
          OP_NOP: w_next_state = S_FETCH;
          OP_JMP: begin
            pc_we        = 1'b1;
            pc_sel       = 1'b1;
            imm_sel      = 2'd2;
            w_next_state = S_FETCH;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST, OP_BEQ:
            w_next_state = S_EXEC;
          default: w_next_state = S_HALT;
        endcase
      end

      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            case (opcode)
              OP_SUB:  alu_op = ALU_SUB;
              OP_AND:  alu_op = ALU_AND;
              OP_OR:   alu_op = ALU_OR;
              default: alu_op = ALU_ADD;
            endcase
            acc_we       = 1'b1;
            flags_we     = 1'b1;
            w_next_state = S_WB;
          end
          OP_ADDI: begin
            alu_src_b    = 1'b1;
            acc_we       = 1'b1;
            flags_we     = 1'b1;
            w_next_state = S_WB;
          end
          OP_LD, OP_ST: begin
            alu_src_b    = 1'b1;
            imm_sel      = 2'd1;
            mar_we       = 1'b1;
            w_next_state = S_MEM;
          end
          OP_BEQ: begin
            // Branch resolves in the compare cycle using the live zero result.
            alu_op       = ALU_SUB;
            flags_we     = 1'b1;
            imm_sel      = 2'd2;
            pc_we        = alu_zero;
            pc_sel       = alu_zero;
            w_next_state = S_FETCH;
          end
          default: w_next_state = S_HALT;
        endcase
      end

      S_MEM: begin
        case (opcode)
          OP_LD: begin
            mem_re = 1'b1;
`ifdef MEM_WAIT_EN
            mdr_we = mem_ready;
            if (mem_ready) w_next_state = S_WB;
`else
            mdr_we       = 1'b1;
            w_next_state = S_WB;
`endif
          end
          OP_ST: begin
            mem_we = 1'b1;
`ifdef MEM_WAIT_EN
            if (mem_ready) w_next_state = S_FETCH;
`else
            w_next_state = S_FETCH;
`endif
          end
          default: w_next_state = S_HALT;
        endcase
      end

      S_WB: begin
        rf_we        = 1'b1;
        rf_wsel      = (opcode == OP_LD);
        w_next_state = S_FETCH;
      end

      default: begin
        // HALT and the unused encoding 7 both park here until reset.
        halted       = 1'b1;
        w_next_state = S_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction expected traces built from the instruction rules.
// Honours MEM_WAIT_EN the same way as the design build.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       alu_zero, mem_ready;
  logic       pc_we, pc_sel, ir_we, reg_ab_we, acc_we, mar_we, mdr_we, flags_we;
  logic       rf_we, rf_wsel, alu_src_b, mem_re, mem_we, halted;
  logic [2:0] alu_op, state;
  logic [1:0] imm_sel;

  always #5 clk = ~clk;

  control_unit #(.OPCODE_W(4), .ALU_OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .reg_ab_we(reg_ab_we), .acc_we(acc_we),
    .mar_we(mar_we), .mdr_we(mdr_we), .flags_we(flags_we), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .imm_sel(imm_sel), .mem_re(mem_re),
    .mem_we(mem_we), .halted(halted), .state(state)
  );

  typedef struct packed {
    logic       pc_we, pc_sel, ir_we, reg_ab_we, acc_we, mar_we, mdr_we, flags_we, rf_we, rf_wsel;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic [1:0] imm_sel;
    logic       mem_re, mem_we, halted;
    logic [2:0] state;
  } outs_t;

  outs_t act;
  assign act = {pc_we, pc_sel, ir_we, reg_ab_we, acc_we, mar_we, mdr_we, flags_we, rf_we, rf_wsel,
                alu_op, alu_src_b, imm_sel, mem_re, mem_we, halted, state};

  int checks = 0;
  int errors = 0;

  function automatic outs_t st_only(input logic [2:0] s);
    outs_t e;
    e = '0;
    e.state = s;
    return e;
  endfunction

  task automatic cmp(input string name, input outs_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, e);
    end
  endtask

  task automatic lit(input string name, input int a, input int x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, a, x);
    end
  endtask

  task automatic step(input string name, input outs_t e, input logic [3:0] op,
                      input logic z, input logic rdy);
    @(posedge clk);
    #1;
    opcode = op; alu_zero = z; mem_ready = rdy;
    @(negedge clk);
    cmp(name, e);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cmp("boot", st_only(3'd0));
  endtask

  // One instruction, cycle by cycle, from FETCH up to (not including) the next FETCH.
  task automatic run_instr(input logic [3:0] op, input logic z, input int nwait,
                           input int nhalt, input bit abort_in_mem);
    outs_t e;
    e = st_only(3'd1); e.ir_we = 1; e.pc_we = 1;
    step("fetch", e, op, z, 1'b0);
    e = st_only(3'd2); e.reg_ab_we = 1;
    if (op == 4'h9) begin e.pc_we = 1; e.pc_sel = 1; e.imm_sel = 2'd2; end
    step("decode", e, op, z, 1'b0);
    if (op == 4'h0 || op == 4'h9) return;
    if (op >= 4'hA) begin
      e = st_only(3'd6); e.halted = 1;
      repeat (nhalt) step("halt", e, op, z, 1'b0);
      return;
    end
    e = st_only(3'd3);
    if (op inside {[4'h1:4'h4]}) begin
      e.alu_op = 3'(op - 4'h1); e.acc_we = 1; e.flags_we = 1;
    end else if (op == 4'h5) begin
      e.alu_src_b = 1; e.acc_we = 1; e.flags_we = 1;
    end else if (op == 4'h6 || op == 4'h7) begin
      e.alu_src_b = 1; e.imm_sel = 2'd1; e.mar_we = 1;
    end else begin
      e.alu_op = 3'b001; e.flags_we = 1; e.imm_sel = 2'd2; e.pc_we = z; e.pc_sel = z;
    end
    step("exec", e, op, z, 1'b0);
    if (op == 4'h8) return;
    if (op == 4'h6 || op == 4'h7) begin
      if (abort_in_mem) begin
        @(posedge clk);
        #1 opcode = op; mem_ready = 1'b0;
        #2;
        lit("st_mem_we_before_rst", int'(mem_we), 1);
        lit("st_state_before_rst", int'(state), 4);
        rst_n = 1'b0;
        #1;
        lit("st_mem_we_after_rst", int'(mem_we), 0);
        lit("st_state_after_rst", int'(state), 0);
        cmp("st_all_zero_in_rst", st_only(3'd0));
        return;
      end
      e = st_only(3'd4);
      if (op == 4'h6) e.mem_re = 1; else e.mem_we = 1;
`ifdef MEM_WAIT_EN
      repeat (nwait) step("mem_wait", e, op, z, 1'b0);
      if (op == 4'h6) e.mdr_we = 1;
      step("mem_ready", e, op, z, 1'b1);
`else
      if (op == 4'h6) e.mdr_we = 1;
      step("mem", e, op, z, 1'b0);
`endif
      if (op == 4'h7) return;
    end
    e = st_only(3'd5); e.rf_we = 1; e.rf_wsel = (op == 4'h6);
    step("wb", e, op, z, 1'b0);
  endtask

  task automatic halt_then_reset(input logic [3:0] op);
    run_instr(op, 1'b0, 0, 20, 1'b0);
    lit("halt_halted", int'(halted), 1);
    lit("halt_state", int'(state), 6);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    lit("halt_rst_halted", int'(halted), 0);
    lit("halt_rst_state", int'(state), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cmp("boot_after_halt", st_only(3'd0));
  endtask

  initial begin
    rst_n = 1'b0; opcode = 4'h0; alu_zero = 1'b0; mem_ready = 1'b0;
    #1;
    lit("reset_state", int'(state), 0);
    cmp("in_reset", st_only(3'd0));
    repeat (2) @(posedge clk);
    #1;
    cmp("in_reset_after_edges", st_only(3'd0));
    release_reset();

    run_instr(4'h1, 1'b0, 0, 0, 1'b0);
    run_instr(4'h2, 1'b1, 0, 0, 1'b0);
    run_instr(4'h3, 1'b0, 0, 0, 1'b0);
    run_instr(4'h4, 1'b1, 0, 0, 1'b0);
    run_instr(4'h5, 1'b0, 0, 0, 1'b0);
    run_instr(4'h6, 1'b0, 3, 0, 1'b0);
    run_instr(4'h7, 1'b1, 1, 0, 1'b0);
    run_instr(4'h8, 1'b1, 0, 0, 1'b0);
    run_instr(4'h8, 1'b0, 0, 0, 1'b0);
    run_instr(4'h9, 1'b0, 0, 0, 1'b0);
    run_instr(4'h0, 1'b1, 0, 0, 1'b0);
    run_instr(4'h1, 1'b0, 0, 0, 1'b0);

    halt_then_reset(4'hC);
    halt_then_reset(4'hF);

    run_instr(4'h7, 1'b0, 0, 0, 1'b1);
    @(negedge clk);
    cmp("held_in_reset", st_only(3'd0));
    release_reset();
    run_instr(4'h6, 1'b0, 2, 0, 1'b0);
    run_instr(4'h1, 1'b0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
